// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and geometry for the instruction-cache miss handler (cache_fill_fsm).
// The optional miss counter is enabled with the CACHE_FILL_PERF_EN macro.
package wisc_cache_pkg;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
  localparam int BLOCK_BYTES     = WORDS_PER_BLOCK * 2;

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {FILL_IDLE, FILL_FILL, FILL_TAG} fill_state_t;

  // Block-aligned base address; low byte-in-block bits cleared.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & BLOCK_MASK;
  endfunction
endpackage

// File: rtl/cache_fill_fsm_if.sv
// Signal bundle between the miss handler, the pipeline/cache and main memory.
// slave = the miss handler; master = its environment (pipeline, cache, memory).
interface cache_fill_if;
  import wisc_cache_pkg::*;

  // Memory return has no ready: a word is consumed in the cycle mem_data_valid is high.
  logic                req_valid;
  logic [ADDR_W-1:0]   miss_addr;
  logic                miss_detected;
  logic [DATA_W-1:0]   mem_data_in;
  logic                mem_data_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_read_en;
  logic [ADDR_W-1:0]   fill_addr;
  logic [DATA_W-1:0]   cache_data_out;
  logic                data_write;
  logic [OFFSET_W-1:0] offset_write;
  logic                tag_write;
  logic                valid_bit;
  logic                fsm_busy;
  logic [15:0]         miss_count;
  fill_state_t         dbg_state;

  modport slave (
    input  req_valid, miss_addr, miss_detected, mem_data_in, mem_data_valid,
    output mem_addr, mem_read_en, fill_addr, cache_data_out, data_write,
           offset_write, tag_write, valid_bit, fsm_busy, miss_count, dbg_state
  );

  modport master (
    output req_valid, miss_addr, miss_detected, mem_data_in, mem_data_valid,
    input  mem_addr, mem_read_en, fill_addr, cache_data_out, data_write,
           offset_write, tag_write, valid_bit, fsm_busy, miss_count, dbg_state
  );
endinterface

// File: rtl/cache_fill_fsm_counter.sv
// Word counter for one side (issue or return) of a block fill.
// o_wrap marks the increment that takes the count from the last word back to 0.
module fill_word_counter
  import wisc_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_inc,
  output logic [OFFSET_W-1:0] o_count,
  output logic                o_wrap
);
  logic [OFFSET_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst)         r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_inc)   r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_wrap  = i_inc & ~i_clear & (r_count == '1);
endmodule

// File: rtl/cache_fill_fsm.sv
// Instruction-cache miss handler: fetches the 8-word block, writes it into the cache, then the tag.
// Define CACHE_FILL_PERF_EN to build the saturating miss_count counter; otherwise it reads 0.
module cache_fill_fsm
  import wisc_cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.slave  bus
);
  fill_state_t         r_state, w_next;
  logic [ADDR_W-1:0]   r_base;
  logic                r_issue_done, r_ret_done;
  logic                r_data_write;
  logic [OFFSET_W-1:0] r_offset;
  logic [DATA_W-1:0]   r_cache_data;

  logic                w_start, w_issue, w_accept;
  logic [OFFSET_W-1:0] w_issue_cnt, w_ret_cnt;
  logic                w_issue_wrap, w_ret_wrap;

  assign w_start  = (r_state == FILL_IDLE) & bus.req_valid & bus.miss_detected;
  assign w_issue  = (r_state == FILL_FILL) & ~r_issue_done;
  // Returns outside FILL or beyond the 8th word are dropped here.
  assign w_accept = (r_state == FILL_FILL) & ~r_ret_done & bus.mem_data_valid;

  fill_word_counter u_issue_cnt (
    .clk(clk), .rst(rst), .i_clear(w_start), .i_inc(w_issue),
    .o_count(w_issue_cnt), .o_wrap(w_issue_wrap)
  );

  fill_word_counter u_ret_cnt (
    .clk(clk), .rst(rst), .i_clear(w_start), .i_inc(w_accept),
    .o_count(w_ret_cnt), .o_wrap(w_ret_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= FILL_IDLE;
      r_base       <= '0;
      r_issue_done <= 1'b0;
      r_ret_done   <= 1'b0;
      r_data_write <= 1'b0;
      r_offset     <= '0;
      r_cache_data <= '0;
    end else begin
      r_state      <= w_next;
      r_data_write <= w_accept;
      if (w_start) begin
        r_base       <= block_base(bus.miss_addr);
        r_issue_done <= 1'b0;
        r_ret_done   <= 1'b0;
      end else begin
        if (w_issue_wrap) r_issue_done <= 1'b1;
        if (w_ret_wrap)   r_ret_done   <= 1'b1;
      end
      if (w_accept) begin
        r_offset     <= w_ret_cnt;
        r_cache_data <= bus.mem_data_in;
      end
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.mem_read_en  = 1'b0;
    bus.mem_addr     = '0;
    bus.fill_addr    = '0;
    bus.fsm_busy     = 1'b0;
    bus.tag_write    = 1'b0;
    bus.valid_bit    = 1'b0;
    bus.data_write   = r_data_write;
    bus.offset_write = r_data_write ? r_offset : '0;
    bus.cache_data_out = r_cache_data;
    bus.dbg_state    = r_state;
    case (r_state)
      FILL_IDLE: begin
        if (w_start) w_next = FILL_FILL;
      end
      FILL_FILL: begin
        bus.fsm_busy  = 1'b1;
        bus.fill_addr = r_base;
        if (w_issue) begin
          bus.mem_read_en = 1'b1;
          // Base is block aligned, so OR-ing the word offset can never carry into the tag.
          bus.mem_addr    = r_base | ADDR_W'({w_issue_cnt, 1'b0});
        end
        if (r_ret_done & r_data_write) w_next = FILL_TAG;
      end
      FILL_TAG: begin
        bus.fsm_busy  = 1'b1;
        bus.fill_addr = r_base;
        bus.tag_write = 1'b1;
        bus.valid_bit = 1'b1;
        w_next        = FILL_IDLE;
      end
      default: w_next = FILL_IDLE;
    endcase
  end

`ifdef CACHE_FILL_PERF_EN
  logic [15:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (!rst)                                 r_miss_count <= '0;
    else if (w_start && r_miss_count != '1)   r_miss_count <= r_miss_count + 1'b1;
  end

  assign bus.miss_count = r_miss_count;
`else
  assign bus.miss_count = '0;
`endif
endmodule
